// File: rtl/digest_serializer_if.sv
// Handshake bundle between a digest source, the serializer and a byte sink.
interface digest_serializer_if #(
  parameter int DIGEST_BITS = 256
);
  logic [DIGEST_BITS-1:0] digest;
  logic                   digest_valid;
  logic                   digest_ready;
  logic                   digest_drop;
  logic [7:0]             dout;
  logic                   dout_valid;
  logic                   dout_ready;
  logic                   dout_last;
  logic                   busy;
  logic                   tx_done;

  modport master (
    output digest, digest_valid, dout_ready,
    input  digest_ready, digest_drop, dout, dout_valid, dout_last, busy, tx_done
  );

  modport slave (
    input  digest, digest_valid, dout_ready,
    output digest_ready, digest_drop, dout, dout_valid, dout_last, busy, tx_done
  );
endinterface

// File: rtl/digest_serializer.sv
// Captures a hash digest and streams it MSB-first as raw bytes or lowercase
// ASCII hex characters over a valid/ready/last byte interface.
module digest_serializer #(
  parameter int DIGEST_BITS = 256,
  parameter int HEX_ASCII   = 0
) (
  input  logic           clk,
  input  logic           rst,
  digest_serializer_if.slave ds_io
);
  localparam int N_ITEMS = (HEX_ASCII != 0) ? DIGEST_BITS / 4 : DIGEST_BITS / 8;
  localparam int STEP    = (HEX_ASCII != 0) ? 4 : 8;
  localparam int CW      = (N_ITEMS > 1) ? $clog2(N_ITEMS) : 1;
  localparam logic [CW-1:0] LAST_IDX = CW'(N_ITEMS - 1);

  typedef enum logic [0:0] {IDLE = 1'b0, SEND = 1'b1} state_t;

  state_t                 state_q, state_d;
  logic [DIGEST_BITS-1:0] shreg_q, shreg_d;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic [7:0]             dout_q, dout_d;
  logic                   dout_valid_q, dout_valid_d;
  logic                   dout_last_q, dout_last_d;
  logic                   busy_q, busy_d;
  logic                   tx_done_q, tx_done_d;
  logic                   drop_q, drop_d;
  logic [DIGEST_BITS-1:0] shifted_s;
  logic [CW-1:0]          cnt_inc_s;

  function automatic logic [7:0] hex_char(input logic [3:0] n);
    if (n < 4'd10) begin
      return {4'h3, n};
    end else begin
      return 8'h61 + {4'h0, n} - 8'd10;
    end
  endfunction

  // The item shown on dout is always taken from the top of the shift register.
  function automatic logic [7:0] item_of(input logic [DIGEST_BITS-1:0] v);
    if (HEX_ASCII != 0) begin
      return hex_char(v[DIGEST_BITS-1 -: 4]);
    end else begin
      return v[DIGEST_BITS-1 -: 8];
    end
  endfunction

  assign shifted_s = shreg_q << STEP;
  assign cnt_inc_s = cnt_q + 1'b1;

  always_comb begin
    state_d      = state_q;
    shreg_d      = shreg_q;
    cnt_d        = cnt_q;
    dout_d       = dout_q;
    dout_valid_d = dout_valid_q;
    dout_last_d  = dout_last_q;
    busy_d       = busy_q;
    tx_done_d    = 1'b0;
    drop_d       = 1'b0;
    case (state_q)
      IDLE: begin
        if (ds_io.digest_valid) begin
          shreg_d      = ds_io.digest;
          cnt_d        = '0;
          dout_d       = item_of(ds_io.digest);
          dout_valid_d = 1'b1;
          dout_last_d  = (LAST_IDX == '0);
          busy_d       = 1'b1;
          state_d      = SEND;
        end else begin
          dout_valid_d = 1'b0;
          dout_last_d  = 1'b0;
          busy_d       = 1'b0;
        end
      end
      SEND: begin
        // A strobe while sending (including on the final edge) is discarded.
        drop_d = ds_io.digest_valid;
        if (ds_io.dout_ready) begin
          if (cnt_q == LAST_IDX) begin
            state_d      = IDLE;
            dout_valid_d = 1'b0;
            dout_last_d  = 1'b0;
            busy_d       = 1'b0;
            tx_done_d    = 1'b1;
          end else begin
            shreg_d     = shifted_s;
            cnt_d       = cnt_inc_s;
            dout_d      = item_of(shifted_s);
            dout_last_d = (cnt_inc_s == LAST_IDX);
          end
        end else begin
          dout_valid_d = 1'b1;
        end
      end
      default: begin
        state_d      = IDLE;
        dout_valid_d = 1'b0;
        dout_last_d  = 1'b0;
        busy_d       = 1'b0;
      end
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      shreg_q      <= '0;
      cnt_q        <= '0;
      dout_q       <= 8'h00;
      dout_valid_q <= 1'b0;
      dout_last_q  <= 1'b0;
      busy_q       <= 1'b0;
      tx_done_q    <= 1'b0;
      drop_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      shreg_q      <= shreg_d;
      cnt_q        <= cnt_d;
      dout_q       <= dout_d;
      dout_valid_q <= dout_valid_d;
      dout_last_q  <= dout_last_d;
      busy_q       <= busy_d;
      tx_done_q    <= tx_done_d;
      drop_q       <= drop_d;
    end
  end

  assign ds_io.digest_ready = (state_q == IDLE);
  assign ds_io.digest_drop  = drop_q;
  assign ds_io.dout         = dout_q;
  assign ds_io.dout_valid   = dout_valid_q;
  assign ds_io.dout_last    = dout_last_q;
  assign ds_io.busy         = busy_q;
  assign ds_io.tx_done      = tx_done_q;
endmodule
